// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture path: default geometry,
// RGB332 colour constants and the capture FSM state encoding.
package cam_pkg;

  localparam int CAM_SCREEN_X_DEF = 160;
  localparam int CAM_SCREEN_Y_DEF = 120;
  localparam int AW_DEF           = 15;
  localparam int DW_DEF           = 8;

  localparam logic [7:0] RED_VGA   = 8'hE0;
  localparam logic [7:0] GREEN_VGA = 8'h1C;
  localparam logic [7:0] BLUE_VGA  = 8'h03;

  typedef enum logic [1:0] {
    S_WAIT_VS_HI = 2'd0,
    S_WAIT_VS_LO = 2'd1,
    S_CAPTURE    = 2'd2
  } cam_state_t;

endpackage

// File: rtl/rgb565_to_rgb332.sv
// Combinational RGB565 -> RGB332 reduction by truncation (top bits of
// each channel kept, no rounding).
module rgb565_to_rgb332 (
  input  logic [15:0] rgb565,
  output logic [7:0]  rgb332
);

  // R = [15:11], G = [10:5], B = [4:0]; keep the MSBs of each channel.
  assign rgb332 = {rgb565[15:13], rgb565[10:8], rgb565[4:3]};

endmodule

// File: rtl/cam_capture_rgb332.sv
// Camera byte-stream capture: frames on VSYNC/HREF, pairs bytes into RGB565,
// converts to RGB332 and writes one pixel per strobe into the frame buffer.
module cam_capture_rgb332
  import cam_pkg::*;
#(
  parameter int CAM_SCREEN_X = CAM_SCREEN_X_DEF,
  parameter int CAM_SCREEN_Y = CAM_SCREEN_Y_DEF,
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cam_vsync,
  input  logic          cam_href,
  input  logic [7:0]    cam_data,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we,
  output logic          frame_done,
  output logic          overrun
);

  localparam int CW = $clog2(CAM_SCREEN_X + 1);
  localparam int RW = $clog2(CAM_SCREEN_Y + 1);
  localparam logic [CW-1:0] COL_MAX     = CW'(CAM_SCREEN_X);
  localparam logic [RW-1:0] ROW_MAX     = RW'(CAM_SCREEN_Y);
  localparam logic [AW-1:0] LINE_STRIDE = AW'(CAM_SCREEN_X);

  cam_state_t    state_reg, state_next;
  logic          start_capture, end_frame;

  logic [RW-1:0] row_reg;
  logic [CW-1:0] col_reg;
  logic          phase_reg;
  logic [7:0]    hi_reg;
  logic          href_d_reg;

  logic          pix_vld_reg;
  logic [15:0]   pix_reg;
  logic [AW-1:0] pix_addr_reg;
  logic [7:0]    pix_rgb332;

  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_data_reg;
  logic          mem_we_reg;
  logic          frame_done_reg;
  logic          overrun_reg;

  logic          in_capture, href_fall, in_bounds;
  logic [AW-1:0] pix_addr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_WAIT_VS_HI;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    start_capture = 1'b0;
    end_frame     = 1'b0;
    case (state_reg)
      S_WAIT_VS_HI: begin
        if (cam_vsync) state_next = S_WAIT_VS_LO;
      end
      S_WAIT_VS_LO: begin
        if (!cam_vsync) begin
          state_next    = S_CAPTURE;
          start_capture = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (cam_vsync) begin
          state_next = S_WAIT_VS_LO;
          end_frame  = 1'b1;
        end
      end
      default: state_next = S_WAIT_VS_HI;
    endcase
  end

  assign in_capture    = (state_reg == S_CAPTURE);
  assign href_fall     = in_capture && href_d_reg && !cam_href;
  assign in_bounds     = (col_reg < COL_MAX) && (row_reg < ROW_MAX);
  assign pix_addr_next = AW'(row_reg) * LINE_STRIDE + AW'(col_reg);

  // Pixel is assembled at the second byte, converted and written one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_reg        <= '0;
      col_reg        <= '0;
      phase_reg      <= 1'b0;
      hi_reg         <= '0;
      href_d_reg     <= 1'b0;
      pix_vld_reg    <= 1'b0;
      pix_reg        <= '0;
      pix_addr_reg   <= '0;
      mem_addr_reg   <= '0;
      mem_data_reg   <= '0;
      mem_we_reg     <= 1'b0;
      frame_done_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      href_d_reg  <= cam_href;
      pix_vld_reg <= 1'b0;
      if (start_capture) begin
        row_reg   <= '0;
        col_reg   <= '0;
        phase_reg <= 1'b0;
      end else if (in_capture) begin
        if (href_fall) begin
          // Line end; an unpaired trailing byte is dropped with the phase reset.
          if (row_reg < ROW_MAX) row_reg <= row_reg + 1'b1;
          col_reg   <= '0;
          phase_reg <= 1'b0;
        end else if (cam_href) begin
          phase_reg <= ~phase_reg;
          if (!phase_reg) begin
            hi_reg <= cam_data;
          end else begin
            pix_reg      <= {hi_reg, cam_data};
            pix_addr_reg <= pix_addr_next;
            if (in_bounds) pix_vld_reg <= 1'b1;
            else           overrun_reg <= 1'b1;
            if (col_reg < COL_MAX) col_reg <= col_reg + 1'b1;
          end
        end
      end

      mem_we_reg     <= pix_vld_reg;
      frame_done_reg <= end_frame;
      if (pix_vld_reg) begin
        mem_addr_reg <= pix_addr_reg;
        mem_data_reg <= DW'(pix_rgb332);
      end
    end
  end

  rgb565_to_rgb332 u_conv (
    .rgb565 (pix_reg),
    .rgb332 (pix_rgb332)
  );

  assign mem_addr   = mem_addr_reg;
  assign mem_data   = mem_data_reg;
  assign mem_we     = mem_we_reg;
  assign frame_done = frame_done_reg;
  assign overrun    = overrun_reg;

endmodule
